// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake and hands the word to decode.
// Optional PC_ALIGN_CHECK_EN traps misaligned next-PC targets in a sticky ERROR state.
//
// state | meaning
// IDLE  | after reset, no request
// FETCH | imem_req high at pc, waiting for imem_ack
// VALID | instr presented to decode; advances when not stalled
// ERROR | misaligned target trapped until reset (PC_ALIGN_CHECK_EN only)

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] seq_pc;
    logic [31:0] target;

    assign seq_pc = pc + 32'd4;

    // Redirect beats branch; branch offset is in words
    always_comb begin
        target = seq_pc;
        if (redirect_valid)
            target = redirect_pc;
        else if (branch_taken)
            target = seq_pc + (branch_offset << 2);
    end

`ifdef PC_ALIGN_CHECK_EN
    logic err, err_nxt;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_q;
`ifdef PC_ALIGN_CHECK_EN
        err_nxt   = err;
`endif
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
                    // pc is left at the faulting instruction so pc_out points at it
                    if (target[1:0] != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = ERROR;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end
`else
                    pc_nxt    = target & 32'hFFFF_FFFC;
                    state_nxt = FETCH;
`endif
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            ERROR: state_nxt = ERROR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= err_nxt;
    end
    assign misalign_err = err;
`else
    assign misalign_err = 1'b0;
`endif

    // Request and valid decode straight from state so reset drops them asynchronously
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == VALID);
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign pc_out      = pc;
    assign pc_plus4    = seq_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: acked words go into a scoreboard and are
// compared against instr/op/pc_out/pc_plus4 when the stage reports valid.
`timescale 1ns/1ps

module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .op             (op),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first VALID cycle: pops the oldest acked word and compares
    task automatic sb_check();
        sb_entry_t e;
        logic [31:0] exp_op;
        check("valid", {31'd0, instr_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            exp_op = {26'd0, e.word[31:26]};
            check("instr", instr, e.word);
            check("op", {26'd0, op}, exp_op);
            check("pc_out", pc_out, e.pc);
            check("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
        check("misalign", {31'd0, misalign_err}, 32'd0);
    endtask

    // Entered in the first FETCH cycle; waits `waits` cycles before acking
    task automatic fetch_ack(input logic [31:0] addr, input logic [31:0] word, input int waits);
        sb_entry_t e;
        for (int i = 0; i < waits; i++) begin
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, addr);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        check("req", {31'd0, imem_req}, 32'd1);
        check("addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        e.pc   = addr;
        e.word = word;
        sb_q.push_back(e);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        sb_check();
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_offset  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        repeat (2) tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_op", {26'd0, op}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);

        rst_n = 1'b1;
        tick();
        fetch_ack(32'h0, 32'h8C01_0004, 0);
        check("op_lw", {26'd0, op}, 32'h23);
        tick();
        fetch_ack(32'h4, 32'h2002_0005, 0);
        tick();
        fetch_ack(32'h8, 32'h0043_1820, 3);
        tick();
        fetch_ack(32'hC, 32'hAC03_0008, 0);
        tick();
        fetch_ack(32'h10, 32'h1062_FFFE, 0);

        // stall holds VALID two cycles, then a backward branch resolves
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_offset = 32'h0000_0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_pc", pc_out, 32'h10);
            check("stall_instr", instr, 32'h1062_FFFE);
        end
        stall         = 1'b0;
        branch_offset = 32'hFFFF_FFFE;
        tick();
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        fetch_ack(32'hC, 32'h0800_0000, 0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        branch_taken   = 1'b1;
        branch_offset  = 32'h100;
        tick();
        redirect_valid = 1'b0;
        branch_taken   = 1'b0;
        branch_offset  = 32'd0;
        fetch_ack(32'h40, 32'h0000_0008, 0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_ack(32'hFFFF_FFFC, 32'h3C01_1234, 0);
        tick();
        fetch_ack(32'h0, 32'h1000_0003, 0);
        tick();

        // Reset during a wait at PC 0x4; a late ack must not be taken
        check("mid_req", {31'd0, imem_req}, 32'd1);
        check("mid_addr", imem_addr, 32'h4);
        tick();
        #2;
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_valid", {31'd0, instr_valid}, 32'd0);
        check("restart_instr", instr, 32'h0);
        imem_ack = 1'b0;
        fetch_ack(32'h0, 32'h2401_0007, 0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check("err_flag", {31'd0, misalign_err}, 32'd1);
            check("err_req", {31'd0, imem_req}, 32'd0);
            check("err_valid", {31'd0, instr_valid}, 32'd0);
            check("err_pc", pc_out, 32'h0);
            tick();
        end
`else
        check("align_addr", imem_addr, 32'h40);
        check("align_req", {31'd0, imem_req}, 32'd1);
        check("align_err", {31'd0, misalign_err}, 32'd0);
`endif
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
